operand_bypass_unit: RTL and testbench

- Parametrised successor to the two-operand register/forward selector in the RISC-V decode stage.
- Supports NUM_PORTS source operands and NUM_STAGES forwarding sources.
- Detects not-yet-ready producers (load-use) and raises a hazard request.
- Captures forwarded data while decode is stalled, so values that drain out of the pipeline are not lost.
- Drives the registered decode→execute operand pipeline register.

---
 rtl/operand_bypass_unit.sv | 157 +++++++++++++++
 tb/tb_operand_bypass_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bypass_unit.sv
// Decode-stage operand bypass: youngest-producer forwarding, load-use hazard detection,
// capture of forwarded data while stalled, and the decode->execute operand register.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module operand_bypass_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_STAGES = 4,
    parameter int RA_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [NUM_PORTS-1:0]       use_rs,
    input  logic [NUM_PORTS-1:0]       sel_reg,
    input  logic [NUM_PORTS*RA_W-1:0]  rs_flat,
    input  logic [NUM_PORTS*XLEN-1:0]  rf_data_flat,
    input  logic [NUM_PORTS*XLEN-1:0]  other_flat,
    input  logic [NUM_STAGES-1:0]      stg_we,
    input  logic [NUM_STAGES-1:0]      stg_ready,
    input  logic [NUM_STAGES*RA_W-1:0] stg_rd_flat,
    input  logic [NUM_STAGES*XLEN-1:0] stg_data_flat,
    output logic                       hazard,
    output logic                       out_valid,
    output logic [NUM_PORTS*XLEN-1:0]  reg_out_flat,
    output logic [NUM_PORTS*XLEN-1:0]  op_out_flat
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                fwd_count,
    output logic [31:0]                hazard_count
`endif
);

    logic [RA_W-1:0] rs       [NUM_PORTS];
    logic [XLEN-1:0] rf_data  [NUM_PORTS];
    logic [XLEN-1:0] other    [NUM_PORTS];
    logic [RA_W-1:0] stg_rd   [NUM_STAGES];
    logic [XLEN-1:0] stg_data [NUM_STAGES];

    logic [NUM_PORTS-1:0] held_valid;
    logic [XLEN-1:0]      held_data [NUM_PORTS];

    logic [NUM_PORTS-1:0] win_found;
    logic [NUM_PORTS-1:0] win_ready;
    logic [NUM_PORTS-1:0] port_hazard;
    logic [XLEN-1:0]      win_data [NUM_PORTS];
    logic [XLEN-1:0]      resolved [NUM_PORTS];
    logic                 advance;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_unpack
        assign rs[p]      = rs_flat[p*RA_W +: RA_W];
        assign rf_data[p] = rf_data_flat[p*XLEN +: XLEN];
        assign other[p]   = other_flat[p*XLEN +: XLEN];
    end

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage_unpack
        assign stg_rd[s]   = stg_rd_flat[s*RA_W +: RA_W];
        assign stg_data[s] = stg_data_flat[s*XLEN +: XLEN];
    end

    // Scan oldest to youngest so the youngest match overwrites; ready plays no part in the choice.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            win_found[p] = 1'b0;
            win_ready[p] = 1'b0;
            win_data[p]  = '0;
            for (int s = NUM_STAGES-1; s >= 0; s--) begin
                if (stg_we[s] && use_rs[p] && (rs[p] != '0) && (stg_rd[s] == rs[p])) begin
                    win_found[p] = 1'b1;
                    win_ready[p] = stg_ready[s];
                    win_data[p]  = stg_data[s];
                end
            end
            if (held_valid[p])
                resolved[p] = held_data[p];
            else if (win_found[p])
                resolved[p] = win_data[p];
            else
                resolved[p] = rf_data[p];
            port_hazard[p] = in_valid && !held_valid[p] && win_found[p] && !win_ready[p];
        end
    end

    assign hazard  = |port_hazard;
    assign advance = !stall && !hazard;

    // Latch ready forwarded values during a stall so they survive the producer leaving the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) held_data[p] <= '0;
        end else if (flush || advance) begin
            held_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) held_data[p] <= '0;
        end else if (stall && in_valid) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!held_valid[p] && win_found[p] && win_ready[p]) begin
                    held_valid[p] <= 1'b1;
                    held_data[p]  <= win_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            reg_out_flat <= '0;
            op_out_flat  <= '0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            reg_out_flat <= '0;
            op_out_flat  <= '0;
        end else if (stall) begin
            out_valid    <= out_valid;
        end else if (hazard) begin
            out_valid    <= 1'b0;
            reg_out_flat <= '0;
            op_out_flat  <= '0;
        end else begin
            out_valid <= in_valid;
            for (int p = 0; p < NUM_PORTS; p++) begin
                reg_out_flat[p*XLEN +: XLEN] <= resolved[p];
                op_out_flat[p*XLEN +: XLEN]  <= sel_reg[p] ? resolved[p] : other[p];
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_ports;
    logic [32:0] fwd_sum;

    always_comb begin
        fwd_ports = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (held_valid[p] || win_found[p]) fwd_ports = fwd_ports + 32'd1;
        end
    end

    assign fwd_sum = {1'b0, fwd_count} + {1'b0, fwd_ports};

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count    <= '0;
            hazard_count <= '0;
        end else begin
            if (advance && in_valid)
                fwd_count <= fwd_sum[32] ? '1 : fwd_sum[31:0];
            if (hazard && !stall && (hazard_count != '1))
                hazard_count <= hazard_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Self-checking bench for operand_bypass_unit (2 ports, 4 stages): vector table plus
// hand-written stall/flush/reset sequences, outputs checked through a scoreboard queue.
module tb_operand_bypass_unit;

    localparam int XLEN = 32;
    localparam int NP   = 2;
    localparam int NS   = 4;
    localparam int RA_W = 5;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        in_valid;
        logic [1:0]  use_rs;
        logic [1:0]  sel_reg;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [31:0] rf0;
        logic [31:0] rf1;
        logic [31:0] oth0;
        logic [31:0] oth1;
        logic [3:0]  we;
        logic [3:0]  rdy;
        logic [19:0] rd_flat;
        logic [127:0] data_flat;
        logic        exp_hazard;
        logic        exp_valid;
        logic [31:0] exp_op0;
        logic [31:0] exp_op1;
        logic [31:0] exp_reg0;
        logic [31:0] exp_reg1;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [31:0] reg0;
        logic [31:0] reg1;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic                 flush;
    logic                 in_valid;
    logic [NP-1:0]        use_rs;
    logic [NP-1:0]        sel_reg;
    logic [NP*RA_W-1:0]   rs_flat;
    logic [NP*XLEN-1:0]   rf_data_flat;
    logic [NP*XLEN-1:0]   other_flat;
    logic [NS-1:0]        stg_we;
    logic [NS-1:0]        stg_ready;
    logic [NS*RA_W-1:0]   stg_rd_flat;
    logic [NS*XLEN-1:0]   stg_data_flat;
    logic                 hazard;
    logic                 out_valid;
    logic [NP*XLEN-1:0]   reg_out_flat;
    logic [NP*XLEN-1:0]   op_out_flat;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    operand_bypass_unit #(.XLEN(XLEN), .NUM_PORTS(NP), .NUM_STAGES(NS), .RA_W(RA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .use_rs        (use_rs),
        .sel_reg       (sel_reg),
        .rs_flat       (rs_flat),
        .rf_data_flat  (rf_data_flat),
        .other_flat    (other_flat),
        .stg_we        (stg_we),
        .stg_ready     (stg_ready),
        .stg_rd_flat   (stg_rd_flat),
        .stg_data_flat (stg_data_flat),
        .hazard        (hazard),
        .out_valid     (out_valid),
        .reg_out_flat  (reg_out_flat),
        .op_out_flat   (op_out_flat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t clearVec();
        vec_t v;
        v.stall = 1'b0;  v.flush = 1'b0;  v.in_valid = 1'b1;
        v.use_rs = 2'b11; v.sel_reg = 2'b11;
        v.rs0 = 5'd1;    v.rs1 = 5'd2;
        v.rf0 = 32'h0A00; v.rf1 = 32'h0B00;
        v.oth0 = 32'h0C00; v.oth1 = 32'h0D00;
        v.we = '0; v.rdy = '0; v.rd_flat = '0; v.data_flat = '0;
        v.exp_hazard = 1'b0; v.exp_valid = 1'b0;
        v.exp_op0 = '0; v.exp_op1 = '0; v.exp_reg0 = '0; v.exp_reg1 = '0;
        return v;
    endfunction

    function automatic vec_t withStage(vec_t v, int s, logic [4:0] rd, logic [31:0] d, logic r);
        v.we[s]              = 1'b1;
        v.rdy[s]             = r;
        v.rd_flat[s*5 +: 5]  = rd;
        v.data_flat[s*32 +: 32] = d;
        return v;
    endfunction

    function automatic vec_t setExp(vec_t v, logic haz, logic val, logic [31:0] op0,
                                    logic [31:0] op1, logic [31:0] reg0, logic [31:0] reg1);
        v.exp_hazard = haz; v.exp_valid = val;
        v.exp_op0 = op0; v.exp_op1 = op1; v.exp_reg0 = reg0; v.exp_reg1 = reg1;
        return v;
    endfunction

    task automatic checkValue(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got 0 entries expected 1", nm);
        end else begin
            e = sbq.pop_front();
            checkValue({nm, ".out_valid"}, 32'(out_valid), 32'(e.valid));
            checkValue({nm, ".op0"},  op_out_flat[31:0],   e.op0);
            checkValue({nm, ".op1"},  op_out_flat[63:32],  e.op1);
            checkValue({nm, ".reg0"}, reg_out_flat[31:0],  e.reg0);
            checkValue({nm, ".reg1"}, reg_out_flat[63:32], e.reg1);
        end
    endtask

    task automatic driveVec(input vec_t v);
        stall = v.stall; flush = v.flush; in_valid = v.in_valid;
        use_rs = v.use_rs; sel_reg = v.sel_reg;
        rs_flat = {v.rs1, v.rs0};
        rf_data_flat = {v.rf1, v.rf0};
        other_flat = {v.oth1, v.oth0};
        stg_we = v.we; stg_ready = v.rdy;
        stg_rd_flat = v.rd_flat; stg_data_flat = v.data_flat;
    endtask

    // Drive one decode cycle, check the combinational hazard, then the registered result.
    task automatic applyStimulus(input vec_t v, input string nm);
        driveVec(v);
        #1;
        checkValue({nm, ".hazard"}, 32'(hazard), 32'(v.exp_hazard));
        sbq.push_back('{v.exp_valid, v.exp_op0, v.exp_op1, v.exp_reg0, v.exp_reg1});
        @(posedge clk);
        #1;
        checkOutput(nm);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        v = clearVec();
        v.in_valid = 1'b0;
        driveVec(v);
        @(posedge clk);
        #1;
        checkValue("reset.hazard", 32'(hazard), 32'h0);
        sbq.push_back('{1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Independent single-cycle vectors, none of which leaves held state behind.
        v = withStage(withStage(clearVec(), 0, 5'd5, 32'h11, 1'b1), 2, 5'd5, 32'h22, 1'b1);
        v.rs0 = 5'd5;
        tbl.push_back(setExp(v, 0, 1, 32'h11, 32'hB00, 32'h11, 32'hB00));
        v = withStage(clearVec(), 0, 5'd0, 32'hDEAD, 1'b1);
        v.rs0 = 5'd0; v.rf0 = 32'h0; v.rs1 = 5'd0; v.rf1 = 32'h55;
        tbl.push_back(setExp(v, 0, 1, 32'h0, 32'h55, 32'h0, 32'h55));
        v = withStage(clearVec(), 1, 5'd5, 32'h77, 1'b1);
        v.rs0 = 5'd5; v.rs1 = 5'd5; v.sel_reg = 2'b00; v.use_rs = 2'b01;
        tbl.push_back(setExp(v, 0, 1, 32'hC00, 32'hD00, 32'h77, 32'hB00));
        v = withStage(withStage(clearVec(), 1, 5'd4, 32'h1, 1'b0), 3, 5'd4, 32'h2, 1'b1);
        v.rs1 = 5'd4;
        tbl.push_back(setExp(v, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0));
        v = withStage(clearVec(), 0, 5'd3, 32'h33, 1'b0);
        v.rs0 = 5'd3; v.in_valid = 1'b0;
        tbl.push_back(setExp(v, 0, 0, 32'h33, 32'hB00, 32'h33, 32'hB00));
        v = withStage(withStage(clearVec(), 2, 5'd6, 32'h66, 1'b1), 3, 5'd6, 32'h67, 1'b1);
        v.rs0 = 5'd6; v.rs1 = 5'd6; v.sel_reg = 2'b10;
        tbl.push_back(setExp(v, 0, 1, 32'hC00, 32'h66, 32'h66, 32'h66));
        v = withStage(clearVec(), 0, 5'd8, 32'h88, 1'b0);
        v.rs0 = 5'd8; v.rs1 = 5'd8; v.use_rs = 2'b00;
        tbl.push_back(setExp(v, 0, 1, 32'hA00, 32'hB00, 32'hA00, 32'hB00));
        v = clearVec();
        v.rs0 = 5'd2; v.rd_flat[4:0] = 5'd2; v.data_flat[31:0] = 32'h22;
        tbl.push_back(setExp(v, 0, 1, 32'hA00, 32'hB00, 32'hA00, 32'hB00));
        v = withStage(clearVec(), 0, 5'd0, 32'h5, 1'b0);
        v.rs0 = 5'd0; v.rf0 = 32'h0;
        tbl.push_back(setExp(v, 0, 1, 32'h0, 32'hB00, 32'h0, 32'hB00));

        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // Load-use: bubble, then the value arrives one stage older; stalled hazard holds.
        v = withStage(clearVec(), 0, 5'd7, 32'h1, 1'b0); v.rs1 = 5'd7;
        applyStimulus(setExp(v, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0), "ldu_bubble");
        v = withStage(clearVec(), 1, 5'd7, 32'h99, 1'b1); v.rs1 = 5'd7;
        applyStimulus(setExp(v, 0, 1, 32'hA00, 32'h99, 32'hA00, 32'h99), "ldu_fwd");
        v = withStage(clearVec(), 0, 5'd7, 32'h1, 1'b0); v.rs1 = 5'd7; v.stall = 1'b1;
        applyStimulus(setExp(v, 1, 1, 32'hA00, 32'h99, 32'hA00, 32'h99), "ldu_stall_hold");
        v.stall = 1'b0;
        applyStimulus(setExp(v, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0), "ldu_unstall_bubble");

        // Capture while stalled, producer disappears, held value still used on release.
        v = clearVec(); v.rf0 = 32'h1000;
        applyStimulus(setExp(v, 0, 1, 32'h1000, 32'hB00, 32'h1000, 32'hB00), "cap_setup");
        v = withStage(clearVec(), 3, 5'd3, 32'hAB, 1'b1); v.rs0 = 5'd3; v.rf0 = 32'h5; v.stall = 1'b1;
        applyStimulus(setExp(v, 0, 1, 32'h1000, 32'hB00, 32'h1000, 32'hB00), "cap_stall");
        v = clearVec(); v.rs0 = 5'd3; v.rf0 = 32'h5; v.stall = 1'b1;
        applyStimulus(setExp(v, 0, 1, 32'h1000, 32'hB00, 32'h1000, 32'hB00), "cap_stall2");
        v.stall = 1'b0;
        applyStimulus(setExp(v, 0, 1, 32'hAB, 32'hB00, 32'hAB, 32'hB00), "cap_release");
        applyStimulus(setExp(v, 0, 1, 32'h5, 32'hB00, 32'h5, 32'hB00), "cap_cleared");

        // Flush together with stall kills the output and drops the captured value.
        v = withStage(clearVec(), 0, 5'd3, 32'hCC, 1'b1); v.rs0 = 5'd3; v.rf0 = 32'h5; v.stall = 1'b1;
        applyStimulus(setExp(v, 0, 1, 32'h5, 32'hB00, 32'h5, 32'hB00), "fl_capture");
        v = clearVec(); v.rs0 = 5'd3; v.stall = 1'b1; v.flush = 1'b1;
        applyStimulus(setExp(v, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0), "fl_flush_stall");
        v = clearVec(); v.rs0 = 5'd3; v.rf0 = 32'h10;
        applyStimulus(setExp(v, 0, 1, 32'h10, 32'hB00, 32'h10, 32'hB00), "fl_after");

        // Asynchronous reset in the middle of a stall with a pending capture.
        v = withStage(clearVec(), 3, 5'd3, 32'hEE, 1'b1); v.rs0 = 5'd3; v.rf0 = 32'h10; v.stall = 1'b1;
        applyStimulus(setExp(v, 0, 1, 32'h10, 32'hB00, 32'h10, 32'hB00), "rst_capture");
        rst_n = 1'b0;
        #1;
        sbq.push_back('{1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
        checkOutput("rst_async");
        rst_n = 1'b1;
        v = clearVec(); v.rs0 = 5'd3; v.rf0 = 32'h10;
        applyStimulus(setExp(v, 0, 1, 32'h10, 32'hB00, 32'h10, 32'hB00), "rst_discard");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
